// File: rtl/pc_branch_unit.sv
// Program counter owner: JP, JP C/NC, JP Z/NZ, JPBA, PSET and plain advance.
// Ports: clk, reset_n, start, op, imm, carry, zero, a_reg, b_reg -> pc, busy, done, taken.
// Optional macro PC_BRANCH_ZERO_COND_EN enables JP Z / JP NZ; otherwise they advance.
module pc_branch_unit #(
  parameter int STEP_WIDTH = 8,
  parameter int PAGE_WIDTH = 4,
  parameter int BANK_WIDTH = 1,
  parameter int CYCLE_LEN  = 5,
  parameter logic [BANK_WIDTH+PAGE_WIDTH+STEP_WIDTH-1:0] RST_VECTOR = 13'h0100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [STEP_WIDTH-1:0] imm,
  input  logic                  carry,
  input  logic                  zero,
  input  logic [3:0]            a_reg,
  input  logic [3:0]            b_reg,
  output logic [BANK_WIDTH+PAGE_WIDTH+STEP_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done,
  output logic                  taken
);

  localparam int BPW = BANK_WIDTH + PAGE_WIDTH;
  localparam int PSW = PAGE_WIDTH + STEP_WIDTH;
  localparam int PCW = BPW + STEP_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JP   = 3'd1;
  localparam logic [2:0] OP_JPC  = 3'd2;
  localparam logic [2:0] OP_JPNC = 3'd3;
  localparam logic [2:0] OP_JPZ  = 3'd4;
  localparam logic [2:0] OP_JPNZ = 3'd5;
  localparam logic [2:0] OP_JPBA = 3'd6;
  localparam logic [2:0] OP_PSET = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_UPDATE,
    S_FINISH
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [2:0]            op_q;
  logic [STEP_WIDTH-1:0] imm_q;
  logic                  carry_q;
  logic                  zero_q;
  logic [3:0]            a_q;
  logic [3:0]            b_q;
  logic                  pend_valid;
  logic [BPW-1:0]        pend_val;

  logic                  cond_take;
  logic [BPW-1:0]        tgt_bp;
  logic [STEP_WIDTH-1:0] ab_step;
  logic [STEP_WIDTH-1:0] tgt_step;
  logic [PCW-1:0]        pc_next;

`ifndef PC_BRANCH_ZERO_COND_EN
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

  always_comb begin
    cond_take = 1'b0;
    unique case (1'b1)
      (op_q == OP_JP):   cond_take = 1'b1;
      (op_q == OP_JPC):  cond_take = carry_q;
      (op_q == OP_JPNC): cond_take = ~carry_q;
`ifdef PC_BRANCH_ZERO_COND_EN
      (op_q == OP_JPZ):  cond_take = zero_q;
      (op_q == OP_JPNZ): cond_take = ~zero_q;
`endif
      (op_q == OP_JPBA): cond_take = 1'b1;
      default:           cond_take = 1'b0;
    endcase
  end

  // A pending PSET redirects the bank/page of the very next target.
  assign tgt_bp   = pend_valid ? pend_val : pc[PCW-1:STEP_WIDTH];
  assign ab_step  = STEP_WIDTH'({b_q, a_q});
  assign tgt_step = (op_q == OP_JPBA) ? ab_step : imm_q;

  // Advance carries step into page; page wraps inside the bank.
  always_comb begin
    pc_next = {pc[PCW-1:PSW], pc[PSW-1:0] + PSW'(1)};
    if (cond_take)
      pc_next = {tgt_bp, tgt_step};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= OP_NOP;
      imm_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      pc         <= RST_VECTOR;
      busy       <= 1'b0;
      done       <= 1'b0;
      taken      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            imm_q   <= imm;
            carry_q <= carry;
            zero_q  <= zero;
            a_q     <= a_reg;
            b_q     <= b_reg;
            cnt     <= 4'd1;
            busy    <= 1'b1;
            state   <= (CYCLE_LEN <= 3) ? S_UPDATE : S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(CYCLE_LEN - 3))
            state <= S_UPDATE;
        end
        S_UPDATE: begin
          pc    <= pc_next;
          done  <= 1'b1;
          taken <= cond_take;
          cnt   <= cnt + 4'd1;
          state <= S_FINISH;
        end
        S_FINISH: begin
          done  <= 1'b0;
          taken <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (op_q == OP_PSET) begin
            pend_valid <= 1'b1;
            pend_val   <= imm_q[BPW-1:0];
          end else begin
            pend_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector bench for pc_branch_unit.
// Table of instructions plus hand sequences for busy, FINISH and reset cases.
module tb_pc_branch_unit;

  localparam int CL = 5;
`ifdef PC_BRANCH_ZERO_COND_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [7:0]  imm = '0;
  logic        carry = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  a_reg = '0;
  logic [3:0]  b_reg = '0;
  logic [12:0] pc;
  logic        busy;
  logic        done;
  logic        taken;

  int tests = 0;
  int fails = 0;

  pc_branch_unit #(.CYCLE_LEN(CL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .imm     (imm),
    .carry   (carry),
    .zero    (zero),
    .a_reg   (a_reg),
    .b_reg   (b_reg),
    .pc      (pc),
    .busy    (busy),
    .done    (done),
    .taken   (taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  imm;
    logic        c;
    logic        z;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [12:0] pc;
    logic        t;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_instr(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    op = v.op; imm = v.imm; carry = v.c; zero = v.z;
    a_reg = v.a; b_reg = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = ~v.op; imm = ~v.imm; carry = ~v.c; zero = ~v.z;
    a_reg = ~v.a; b_reg = ~v.b;
    n = 1;
    chk({nm, " busy1"}, 32'(busy), 32'd1);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, CL - 1);
    chk({nm, " pc"}, 32'(pc), 32'(v.pc));
    chk({nm, " taken"}, 32'(taken), 32'(v.t));
    @(negedge clk);
    chk({nm, " idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd2, 8'hCD, 1'b0, 1'b0, 4'h0, 4'h0, 13'h0101, 1'b0};
    tbl[1]  = '{3'd6, 8'h00, 1'b0, 1'b0, 4'h5, 4'hA, 13'h01A5, 1'b1};
    tbl[2]  = '{3'd2, 8'hCD, 1'b1, 1'b0, 4'h0, 4'h0, 13'h01CD, 1'b1};
    tbl[3]  = '{3'd3, 8'hF1, 1'b0, 1'b0, 4'h0, 4'h0, 13'h01F1, 1'b1};
    tbl[4]  = '{3'd3, 8'h22, 1'b1, 1'b0, 4'h0, 4'h0, 13'h01F2, 1'b0};
    tbl[5]  = '{3'd1, 8'hFF, 1'b0, 1'b0, 4'h0, 4'h0, 13'h01FF, 1'b1};
    tbl[6]  = '{3'd0, 8'h77, 1'b1, 1'b1, 4'h0, 4'h0, 13'h0200, 1'b0};
    tbl[7]  = '{3'd4, 8'h33, 1'b0, 1'b1, 4'h0, 4'h0,
                ZC ? 13'h0233 : 13'h0201, ZC};
    tbl[8]  = '{3'd5, 8'h44, 1'b0, 1'b0, 4'h0, 4'h0,
                ZC ? 13'h0244 : 13'h0202, ZC};
    tbl[9]  = '{3'd4, 8'h55, 1'b0, 1'b0, 4'h0, 4'h0,
                ZC ? 13'h0245 : 13'h0203, 1'b0};
    tbl[10] = '{3'd1, 8'hFF, 1'b0, 1'b0, 4'h0, 4'h0, 13'h02FF, 1'b1};
    tbl[11] = '{3'd7, 8'h0F, 1'b0, 1'b0, 4'h0, 4'h0, 13'h0300, 1'b0};
    tbl[12] = '{3'd1, 8'hFF, 1'b0, 1'b0, 4'h0, 4'h0, 13'h0FFF, 1'b1};
    tbl[13] = '{3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 13'h0000, 1'b0};
    tbl[14] = '{3'd7, 8'h13, 1'b0, 1'b0, 4'h0, 4'h0, 13'h0001, 1'b0};
    tbl[15] = '{3'd1, 8'h42, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1342, 1'b1};
    tbl[16] = '{3'd1, 8'h10, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1310, 1'b1};
    tbl[17] = '{3'd7, 8'h02, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1311, 1'b0};
    tbl[18] = '{3'd7, 8'h05, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1312, 1'b0};
    tbl[19] = '{3'd2, 8'h99, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1313, 1'b0};
    tbl[20] = '{3'd1, 8'h77, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1377, 1'b1};
    tbl[21] = '{3'd1, 8'hFF, 1'b0, 1'b0, 4'h0, 4'h0, 13'h13FF, 1'b1};
    tbl[22] = '{3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1400, 1'b0};
    tbl[23] = '{3'd7, 8'h1F, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1401, 1'b0};
    tbl[24] = '{3'd1, 8'hFF, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1FFF, 1'b1};
    tbl[25] = '{3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1000, 1'b0};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst pc", 32'(pc), 32'h0100);
    chk("rst flags", 32'({busy, done, taken}), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++)
      do_instr(tbl[i], $sformatf("vec%0d", i));

    // start during busy and during FINISH are both dropped
    @(negedge clk);
    op = 3'd1; imm = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 3'd1; imm = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy c3", 32'({busy, done}), 32'b10);
    @(negedge clk);
    chk("done c4", 32'(done), 32'd1);
    chk("pc c4", 32'(pc), 32'h1055);
    op = 3'd1; imm = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fin start", 32'({busy, done}), 32'd0);
    repeat (3) @(negedge clk);
    chk("no queue", 32'({busy, pc}), 32'h1055);

    // reset mid taken JP with a pending PSET
    do_instr('{3'd7, 8'h1F, 1'b0, 1'b0, 4'h0, 4'h0, 13'h1056, 1'b0}, "pset");
    @(negedge clk);
    op = 3'd1; imm = 8'h66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort pc", 32'(pc), 32'h0100);
    chk("abort busy", 32'({busy, done}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_instr('{3'd2, 8'hCD, 1'b1, 1'b0, 4'h0, 4'h0, 13'h01CD, 1'b1}, "post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
